// File: rtl/fpu_addsub_sched.sv
// Round-robin issue scheduler sharing one pipelined FP add/sub datapath between two
// requesters, with credit-protected per-requester first-word-fall-through response FIFOs.
module fpu_addsub_sched #(
  parameter int num_bits = 16,
  parameter int LAT      = 3,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [num_bits-1:0] req0_a,
  input  logic [num_bits-1:0] req0_b,
  input  logic                req0_sub,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [num_bits-1:0] req1_a,
  input  logic [num_bits-1:0] req1_b,
  input  logic                req1_sub,
  output logic                dp_valid,
  output logic [num_bits-1:0] dp_a,
  output logic [num_bits-1:0] dp_b,
  input  logic [num_bits-1:0] dp_result,
  input  logic [5:0]          dp_flags,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [num_bits-1:0] rsp0_result,
  output logic [5:0]          rsp0_flags,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [num_bits-1:0] rsp1_result,
  output logic [5:0]          rsp1_flags,
  output logic                busy
);
  // Handshake: a request transfers on a rising edge where valid && ready; ready is a
  // pure function of valids and credits, so the requester never waits on its own valid.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = num_bits + 6;

  logic [1:0]          elig, grant, push, pop, rsp_valid_v, rsp_ready_v;
  logic [CW-1:0]       cnt [2];
  logic [CW-1:0]       occ [2];
  logic [PW-1:0]       wp [2];
  logic [PW-1:0]       rp [2];
  logic [EW-1:0]       mem [2][DEPTH];
  logic [EW-1:0]       head0, head1;
  logic                last_grant, accept, acc_id, dp_id, sel_sub;
  logic [num_bits-1:0] sel_a, sel_b;
  logic [LAT-1:0]      trk_v, trk_id;

  assign rsp_ready_v = {rsp1_ready, rsp0_ready};

  always_comb begin
    elig[0] = req0_valid && (cnt[0] < CW'(DEPTH));
    elig[1] = req1_valid && (cnt[1] < CW'(DEPTH));
    grant   = elig;
    // On a tie the requester that did not win last time gets the slot.
    if (elig == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
    accept  = |grant;
    acc_id  = grant[1];
    sel_a   = acc_id ? req1_a   : req0_a;
    sel_b   = acc_id ? req1_b   : req0_b;
    sel_sub = acc_id ? req1_sub : req0_sub;
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // The op leaving the last tracker stage owns the datapath output this cycle.
  assign push[0] = trk_v[LAT-1] & ~trk_id[LAT-1];
  assign push[1] = trk_v[LAT-1] &  trk_id[LAT-1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rsp_valid_v[i] = (occ[i] != '0);
      pop[i]         = rsp_valid_v[i] & rsp_ready_v[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      dp_valid   <= 1'b0;
      dp_a       <= '0;
      dp_b       <= '0;
      dp_id      <= 1'b0;
      trk_v      <= '0;
      trk_id     <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
        occ[i] <= '0;
        wp[i]  <= '0;
        rp[i]  <= '0;
      end
    end else begin
      dp_valid <= accept;
      if (accept) begin
        last_grant <= acc_id;
        dp_id      <= acc_id;
        dp_a       <= sel_a;
        // Subtract becomes add: b's sign flips unconditionally, NaNs included.
        dp_b       <= sel_b ^ {sel_sub, {(num_bits-1){1'b0}}};
      end
      trk_v[0]  <= dp_valid;
      trk_id[0] <= dp_id;
      for (int k = 1; k < LAT; k++) begin
        trk_v[k]  <= trk_v[k-1];
        trk_id[k] <= trk_id[k-1];
      end
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wp[i] <= wp[i] + PW'(1);
        if (pop[i])  rp[i] <= rp[i] + PW'(1);
        occ[i] <= occ[i] + CW'(push[i]) - CW'(pop[i]);
        cnt[i] <= cnt[i] + CW'(grant[i]) - CW'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wp[i]] <= {dp_result, dp_flags};
    end
  end

  assign head0 = mem[0][rp[0]];
  assign head1 = mem[1][rp[1]];

  assign rsp0_valid  = rsp_valid_v[0];
  assign rsp1_valid  = rsp_valid_v[1];
  assign rsp0_result = rsp_valid_v[0] ? head0[EW-1:6] : '0;
  assign rsp0_flags  = rsp_valid_v[0] ? head0[5:0]    : '0;
  assign rsp1_result = rsp_valid_v[1] ? head1[EW-1:6] : '0;
  assign rsp1_flags  = rsp_valid_v[1] ? head1[5:0]    : '0;

  // Credits cover both in-flight ops and buffered results.
  assign busy = (cnt[0] != '0) || (cnt[1] != '0);
endmodule

// File: doc/fpu_addsub_sched.md
# fpu_addsub_sched

Issue scheduler that shares one pipelined FP add/sub datapath (operand classification, alignment/add, normalise/round) between two requesters. It arbitrates round-robin, converts subtract into add by flipping b's sign, and tracks in-flight operations by requester. Results are steered into per-requester response FIFOs. Credit accounting ensures a result never arrives at a full FIFO, so the datapath never needs to stall.

## Interface
- num_bits, 16: operand/result width (IEEE layout, sign at MSB)
- LAT, 3: fixed datapath latency in cycles, legal 1..8
- DEPTH, 4: entries per response FIFO, power of two, 2..16
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  num_bits  operands
- req0_sub / req1_sub  in  1  1 = a-b, 0 = a+b
- dp_valid  out  1  operation issued to datapath this cycle
- dp_a, dp_b  out  num_bits  datapath operands; dp_b already sign-adjusted
- dp_result  in  num_bits  datapath result, valid exactly LAT cycles after dp_valid
- dp_flags  in  6  result class {SNan,QNan,Norm,subN,inf,zero}, one-hot, same timing as dp_result
- rsp0_valid / rsp1_valid  out  1  FIFO head present
- rsp0_ready / rsp1_ready  in  1  consumer pops head when valid&ready
- rsp0_result / rsp1_result  out  num_bits  head result
- rsp0_flags / rsp1_flags  out  6  head class flags
- busy  out  1  any op in flight or any FIFO non-empty

## Operation
- Credits: one counter per requester, cnt_i ∈ 0..DEPTH, counting in-flight ops plus FIFO occupancy.
  - +1 on accept, -1 on rsp pop; no change when both occur in the same cycle.
  - Requester i is eligible when reqi_valid and cnt_i < DEPTH.
- Arbiter: 1-bit last-grant pointer.
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one not last granted.
  - The pointer updates only on an accept.
  - At most one accept per cycle.
  - reqi_ready is combinational: 1 iff i is granted. It is 0 for a requester that is not valid.
- Issue register: on accept, capture dp_a = a and dp_b = b ^ (sub << num_bits-1), with the sign flipped unconditionally (NaN included). Set dp_valid=1 next cycle, otherwise 0.
- In-flight tracker: LAT-stage shift register of {valid, id}. Stage 0 loads {dp_valid, id of issued op}. The last stage qualifies dp_result/dp_flags.
  - When the last stage is valid, push {dp_result, dp_flags} into FIFO[id].
  - Unqualified dp_result is ignored.
- FIFOs: first-word-fall-through with circular read/write pointers that wrap modulo DEPTH.
  - Simultaneous push and pop is allowed, including when full (pop frees the slot) and when empty (pushed entry is visible next cycle, not same cycle).
  - A push to a full FIFO is a design error; the bench asserts it never occurs.
- Ordering: results per requester are returned in acceptance order. No ordering is guaranteed between requesters.

## Timing
- Reset (async assert, sync-safe deassert): every output is 0, except req*_ready, which follows the combinational rule and reads 0 while req*_valid=0.
  - Pointer resets so req0 wins the first tie.
  - Credits are 0, FIFOs are empty, the tracker is cleared, dp_a/dp_b = 0.
- Reset mid-operation discards all in-flight and buffered results. Datapath outputs arriving after reset are ignored because the tracker is clear.
- Accept at edge E. Then:
  - dp_valid is high in cycle E+1.
  - dp_result is valid in cycle E+1+LAT.
  - The result is written at the end of that cycle.
  - rspi_valid is high from cycle E+2+LAT if the FIFO was empty.
  - Minimum latency is LAT+2 cycles (5 for LAT=3).
- Throughput: 1 op/cycle sustained when both consumers keep ready=1.
- A stalled consumer i blocks only requester i after DEPTH outstanding ops. The other requester continues at full rate.
- busy falls in the cycle after the last FIFO pop, once the tracker is empty.

## Test plan
- Single add, LAT=3: req0 a=0x3C00 b=0x4000 sub=0 accepted at edge 0 -> dp_valid in cycle 1 with dp_b=0x4000; model returns 0x4200/Norm in cycle 4 -> rsp0_valid in cycle 5, rsp0_result=0x4200, flags=Norm.
- Subtract conversion: req1 a=0x4200 b=0x3C00 sub=1 -> dp_b=0xBC00 -> rsp1_result=0x4000. Also check b=0x7E00 (QNaN), sub=1 -> dp_b=0xFE00.
- Tie arbitration: both valid every cycle for 8 cycles -> grants alternate 0,1,0,1…, starting with req0 after reset; each requester receives 4 results in order.
- Credit backpressure: rsp0_ready=0, req0 streams -> exactly DEPTH=4 accepted, then req0_ready=0 while req1 still accepted every cycle; rsp0_ready=1 for one cycle -> exactly one further req0 accept; no FIFO overflow.
- Simultaneous push/pop on full FIFO and on empty FIFO -> occupancy correct, no data loss or duplication, results in order.
- Reset with 3 ops in flight and 2 buffered -> all outputs 0 immediately; datapath results arriving afterwards are not pushed; busy=0 and rsp*_valid=0 until new traffic.
